// File: rtl/joojump_pkg.sv
// Shared definitions for the JooJump button controller: register map and CTRL layout.
package joojump_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_POL = 1;

    // Field order matches the CTRL bit indices above (en in bit 0).
    typedef struct packed {
        logic pol;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/joojump_debounce.sv
// One button: 2-FF synchroniser, hold-time debounce counter and edge pulses on acceptance.
module joojump_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (sync2 != dout) && (cnt == CNT_MAX);
    // Pulses fire on the same clock that dout takes the new level.
    assign rise   = accept &  sync2;
    assign fall   = accept & ~sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (accept) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/joojump_button_ctrl.sv
// Avalon-MM button controller: debounced levels, sticky edge flags, maskable level IRQ.
module joojump_button_ctrl
    import joojump_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [N_BTN-1:0] stable, rise, fall, cap;
    logic [N_BTN-1:0] mask, edge_r, edge_clr;
    ctrl_t            ctrl;
    logic             wr_en, rd_en;
    logic [31:0]      rd_mux;
    logic             unused_wd;

    genvar i;
    generate
        for (i = 0; i < N_BTN; i++) begin : g_btn
            joojump_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .clk    (clk),
                .reset_n(reset_n),
                .din    (btn_in[i]),
                .dout   (stable[i]),
                .rise   (rise[i]),
                .fall   (fall[i])
            );
        end
    endgenerate

    assign wr_en     = chipselect & write;
    assign rd_en     = chipselect & read;
    assign cap       = ctrl.pol ? fall : rise;
    assign edge_clr  = (wr_en && address == ADDR_EDGE) ? writedata[N_BTN-1:0] : '0;
    assign unused_wd = &{1'b0, writedata};

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[N_BTN-1:0] = stable;
            ADDR_MASK: rd_mux[N_BTN-1:0] = mask;
            ADDR_EDGE: rd_mux[N_BTN-1:0] = edge_r;
            ADDR_CTRL: begin
                rd_mux[CTRL_EN]  = ctrl.en;
                rd_mux[CTRL_POL] = ctrl.pol;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask     <= '0;
            edge_r   <= '0;
            ctrl     <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            if (wr_en && address == ADDR_MASK) mask <= writedata[N_BTN-1:0];
            if (wr_en && address == ADDR_CTRL) ctrl <= writedata[1:0];
            // Clear first, then OR in new captures so a simultaneous set wins.
            edge_r <= (edge_r & ~edge_clr) | cap;
            irq    <= ctrl.en & |(edge_r & mask);
            if (rd_en) readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_joojump_button_ctrl.sv
// Directed and randomized checks of joojump_button_ctrl against a window-based reference model.
module tb_joojump_button_ctrl;

    localparam int NB = 4;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] btn_in = '0;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic          irq;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: a button flips once its last DC synchronised samples all disagree with it.
    logic [NB-1:0] m_stable, m_mask, m_edge;
    logic [1:0]    m_ctrl;
    logic          m_irq;
    logic [31:0]   m_rd;
    logic [NB-1:0] ph[$];

    joojump_button_ctrl #(.N_BTN(NB), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_in    (btn_in),
        .address   (address),
        .chipselect(chipselect),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stable = '0; m_mask = '0; m_edge = '0; m_ctrl = '0; m_irq = 1'b0; m_rd = '0;
        ph.delete();
        for (int k = 0; k < DC + 2; k++) ph.push_back('0);
    endtask

    task automatic model_step();
        logic [NB-1:0] nst, cap;
        logic [31:0]   mux;
        logic          flip;
        ph.push_front(btn_in);
        void'(ph.pop_back());
        nst = m_stable;
        cap = '0;
        for (int i = 0; i < NB; i++) begin
            flip = 1'b1;
            for (int k = 2; k < DC + 2; k++)
                if (ph[k][i] == m_stable[i]) flip = 1'b0;
            if (flip) begin
                nst[i] = ~m_stable[i];
                if (nst[i] != m_ctrl[1]) cap[i] = 1'b1;
            end
        end
        mux = '0;
        case (address)
            2'd0: mux[NB-1:0] = m_stable;
            2'd1: mux[NB-1:0] = m_mask;
            2'd2: mux[NB-1:0] = m_edge;
            default: mux[1:0] = m_ctrl;
        endcase
        if (chipselect && read) m_rd = mux;
        m_irq = m_ctrl[0] & |(m_edge & m_mask);
        if (chipselect && write) begin
            case (address)
                2'd1: m_mask = writedata[NB-1:0];
                2'd2: m_edge = m_edge & ~writedata[NB-1:0];
                2'd3: m_ctrl = writedata[1:0];
                default: ;
            endcase
        end
        m_edge   = m_edge | cap;
        m_stable = nst;
    endtask

    // One clock: drive at negedge, model at posedge, compare at the next negedge.
    task automatic cyc(input logic [NB-1:0] b, input logic c, input logic r, input logic w,
                       input logic [1:0] a, input logic [31:0] d);
        btn_in = b; chipselect = c; read = r; write = w; address = a; writedata = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("readdata", readdata, m_rd);
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic idle(input int n, input logic [NB-1:0] b);
        for (int k = 0; k < n; k++) cyc(b, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input logic [NB-1:0] b);
        cyc(b, 1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd_reg(input logic [1:0] a, input logic [NB-1:0] b);
        cyc(b, 1'b1, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [NB-1:0] b;
        int            op;
        model_reset();

        // Clean press with IRQ enabled; DATA reads track the 2+DC latency.
        do_reset();
        wr_reg(2'd1, 32'h1, 4'h0);
        wr_reg(2'd3, 32'h1, 4'h0);
        for (int k = 1; k <= 20; k++) begin
            rd_reg(2'd0, 4'h1);
            chk("press_data", readdata, (k >= 7) ? 32'h1 : 32'h0);
        end
        rd_reg(2'd2, 4'h1);
        chk("press_edge", readdata, 32'h1);
        chk("press_irq", {31'b0, irq}, 32'h1);

        // Glitch shorter than the debounce window is ignored.
        do_reset();
        wr_reg(2'd1, 32'hF, 4'h0);
        wr_reg(2'd3, 32'h1, 4'h0);
        for (int k = 0; k < 3; k++) rd_reg(2'd0, 4'h2);
        for (int k = 0; k < 8; k++) rd_reg(2'd0, 4'h0);
        chk("glitch_data", readdata, 32'h0);
        rd_reg(2'd2, 4'h0);
        chk("glitch_edge", readdata, 32'h0);
        chk("glitch_irq", {31'b0, irq}, 32'h0);

        // W1C of bit0 coinciding with btn2 acceptance; then clear bit2.
        do_reset();
        wr_reg(2'd1, 32'hF, 4'h0);
        wr_reg(2'd3, 32'h1, 4'h0);
        idle(10, 4'h1);
        idle(5, 4'h5);
        wr_reg(2'd2, 32'h1, 4'h5);
        rd_reg(2'd2, 4'h5);
        chk("w1c_race_edge", readdata, 32'h4);
        wr_reg(2'd2, 32'h4, 4'h5);
        chk("w1c_irq_hold", {31'b0, irq}, 32'h1);
        idle(1, 4'h5);
        chk("w1c_irq_drop", {31'b0, irq}, 32'h0);
        rd_reg(2'd2, 4'h5);
        chk("w1c_edge", readdata, 32'h0);

        // Release polarity.
        do_reset();
        wr_reg(2'd1, 32'hF, 4'h0);
        wr_reg(2'd3, 32'h3, 4'h0);
        idle(10, 4'h8);
        rd_reg(2'd2, 4'h8);
        chk("pol_press_edge", readdata, 32'h0);
        idle(10, 4'h0);
        rd_reg(2'd2, 4'h0);
        chk("pol_release_edge", readdata, 32'h8);

        // Masked capture, then unmask.
        do_reset();
        wr_reg(2'd3, 32'h1, 4'h0);
        idle(10, 4'h1);
        rd_reg(2'd2, 4'h1);
        chk("mask_edge", readdata, 32'h1);
        chk("mask_irq_off", {31'b0, irq}, 32'h0);
        wr_reg(2'd1, 32'h1, 4'h1);
        idle(1, 4'h1);
        chk("mask_irq_on", {31'b0, irq}, 32'h1);

        // Reset mid-debounce with btn1 held through reset.
        do_reset();
        wr_reg(2'd1, 32'hF, 4'h0);
        wr_reg(2'd3, 32'h1, 4'h0);
        idle(3, 4'h2);
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            rd_reg(2'd0, 4'h2);
            chk("rst_db_data", readdata, (k >= 7) ? 32'h2 : 32'h0);
        end
        rd_reg(2'd2, 4'h2);
        chk("rst_db_edge", readdata, 32'h2);
        rd_reg(2'd1, 4'h2);
        chk("rst_db_mask", readdata, 32'h0);
        rd_reg(2'd3, 4'h2);
        chk("rst_db_ctrl", readdata, 32'h0);

        // Randomized traffic against the model.
        do_reset();
        b = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) b[$urandom_range(0, NB - 1)] ^= 1'b1;
            op = $urandom_range(0, 9);
            cyc(b, op != 9, op < 6 || op == 9, op >= 6 && op < 9,
                2'($urandom_range(0, 3)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
